mtrap_sequencer: RTL and testbench
==================================

// Module: mtrap_sequencer
// PURPOSE
//  Machine-mode trap/MRET sequencer for priv. ISA 1.12 (M + U modes). Selects the winning trap source
//  (enabled interrupt, pipeline exception, or MRET), drains the pipeline, atomically commits mepc/mcause/
//  mtval/mstatus plus the privilege level, then issues a redirect PC. Sits between the pipeline hazard
//  unit and the machine CSR file; it owns the current privilege-level register.
// PARAMETERS
//  RESET_PRIV   M_MODE  privilege level after reset (priv_level_t)
//  U_MODE_SUPP  1       1: MRET may return to U; 0: MPP is forced to M_MODE on every write
// PORTS
//  CLK            in   1   clock
//  RST            in   1   reset, synchronous, active-high
//  exc_valid      in   1   pipeline reports a synchronous exception at commit
//  exc_code       in   31  ex_code_t cause of that exception
//  exc_pc         in   32  PC of faulting instruction
//  exc_tval       in   32  trap value (bad addr / instruction bits)
//  int_pc         in   32  PC of next instruction to commit (mepc for interrupts)
//  mret_valid     in   1   MRET at commit
//  csr_mip        in   32  mip_t
//  csr_mie        in   32  mie_t
//  csr_mstatus    in   32  mstatus_t
//  csr_mtvec      in   32  mtvec_t
//  csr_mepc       in   32  current mepc (MRET target)
//  pipe_quiesced  in   1   pipeline empty, no outstanding memory ops
//  redirect_ack   in   1   fetch accepted redirect
//  flush_req      out  1   request flush/stall of the pipeline
//  csr_trap_we    out  1   one-cycle strobe: write mepc/mcause/mtval/mstatus
//  csr_mret_we    out  1   one-cycle strobe: write mstatus only
//  mepc_wdata     out  32
//  mcause_wdata   out  32  mcause_t
//  mtval_wdata    out  32
//  mstatus_wdata  out  32  mstatus_t
//  redirect_valid out  1
//  redirect_pc    out  32
//  priv_level     out  2   priv_level_t current privilege
//  busy           out  1   FSM not IDLE
// BEHAVIOUR
//  Reset: state IDLE, priv_level=RESET_PRIV, every other output 0, latched capture regs 0.
//  Interrupt pending: pend = csr_mip & csr_mie; globally enabled if priv_level!=M_MODE or mstatus.mie.
//   Priority MEI(11) > MSI(3) > MTI(7); S-mode bits ignored.
//  Source priority in IDLE (same cycle): interrupt > exception > MRET. Lower sources are dropped; the
//   pipeline re-presents them after redirect.
//  FSM IDLE -> DRAIN -> COMMIT -> REDIRECT -> IDLE:
//   IDLE: on winning source latch {kind, cause, pc, tval}; next DRAIN. flush_req=1 from the next cycle.
//   DRAIN: flush_req=1 until pipe_quiesced=1 (may be the first DRAIN cycle); then COMMIT.
//   COMMIT (exactly 1 cycle, flush_req=1):
//    trap: csr_trap_we=1; mepc={pc[31:2],2'b00}; mcause={int,cause}; mtval=tval (0 for interrupts);
//     mstatus: mpie<=mie, mie<=0, mpp<=priv_level, other fields unchanged; priv_level<=M_MODE.
//    MRET: csr_mret_we=1; mstatus: mie<=mpie, mpie<=1, mpp<=U_MODE (M_MODE if !U_MODE_SUPP),
//     mprv<=0 if new priv!=M; priv_level<=mpp (S/RESERVED map to U_MODE).
//   REDIRECT: redirect_valid=1, flush_req=1, redirect_pc stable until redirect_ack; then IDLE.
//    trap target: {mtvec.base,2'b00}; MRET target: {csr_mepc[31:2],2'b00}.
//  Minimum latency request->redirect_valid: 3 cycles. New requests are ignored while busy.
//  Interrupt deasserting during DRAIN: trap still taken with the latched cause (no cancel).
//  Reset in any state: immediate IDLE, no CSR strobe, redirect_valid dropped.
// CONFIGURATION
//  MTVEC_VECTORED_EN defined: mtvec.mode==VECTORED and interrupt -> target {base,2'b00}+4*cause;
//   exceptions always use base. Undefined: mode field ignored, all traps DIRECT. RES_0/RES_1 -> DIRECT.
// STRUCTURE
//  machine_mode_types_1_12_pkg gains: mtrap_state_t enum {IDLE,DRAIN,COMMIT,REDIRECT},
//   trap_kind_t {TK_INT,TK_EXC,TK_MRET}, mcause bit-index constants for MEI/MSI/MTI.
//  Sub-module mtrap_int_prio: combinational pend/enable -> {valid, int_code_t}.
// TESTING
//  1 priv=M, mstatus.mie=1, mie.mtie=1, mip.mtip=1, int_pc=0x100, mtvec=0x8000_0000 DIRECT, quiesced=1
//    -> mcause=0x8000_0007, mepc=0x100, mtval=0, mie->0, mpie->1, mpp=M, redirect_pc=0x8000_0000 @+3.
//  2 MEI+MTI pending with exc_valid ILLEGAL_INSN same cycle -> mcause=0x8000_000B; exception dropped.
//  3 priv=U, mstatus.mie=0, mip.msip/mie.msie=1 -> trap taken; mpp=U, priv_level=M.
//  4 MRET with mpie=1, mpp=U, mepc=0x204 -> mie=1, mpie=1, mpp=U, priv_level=U, redirect_pc=0x204.
//  5 exc L_ADDR_MAL tval=0x1003, pipe_quiesced low 5 cycles -> flush_req held, single csr_trap_we after.
//  6 MTVEC_VECTORED_EN, mtvec=0x8000_0001, MEI -> redirect_pc=0x8000_002C; RST mid-DRAIN -> IDLE, no write.

Source files
------------

// File: rtl/machine_mode_types_1_12_pkg.sv
// Machine-mode (privileged ISA 1.12, M + U) CSR field types shared by the trap
// sequencer and the machine CSR file.
package machine_mode_types_1_12_pkg;

  typedef enum logic [1:0] {
    U_MODE   = 2'b00,
    S_MODE   = 2'b01,
    RESERVED = 2'b10,
    M_MODE   = 2'b11
  } priv_level_t;

  typedef enum logic [30:0] {
    INSN_ADDR_MAL     = 31'd0,
    INSN_ACCESS_FAULT = 31'd1,
    ILLEGAL_INSN      = 31'd2,
    BREAKPOINT        = 31'd3,
    L_ADDR_MAL        = 31'd4,
    L_ACCESS_FAULT    = 31'd5,
    S_ADDR_MAL        = 31'd6,
    S_ACCESS_FAULT    = 31'd7,
    ECALL_UMODE       = 31'd8,
    ECALL_MMODE       = 31'd11,
    INSN_PAGE_FAULT   = 31'd12,
    L_PAGE_FAULT      = 31'd13,
    S_PAGE_FAULT      = 31'd15
  } ex_code_t;

  typedef enum logic [30:0] {
    INT_MSI = 31'd3,
    INT_MTI = 31'd7,
    INT_MEI = 31'd11
  } int_code_t;

  localparam int unsigned MSI_BIT = 3;
  localparam int unsigned MTI_BIT = 7;
  localparam int unsigned MEI_BIT = 11;

  typedef logic [31:0] mip_t;
  typedef logic [31:0] mie_t;

  typedef struct packed {
    logic        sd;
    logic [7:0]  wpri0;
    logic        tsr;
    logic        tw;
    logic        tvm;
    logic        mxr;
    logic        sum;
    logic        mprv;
    logic [1:0]  xs;
    logic [1:0]  fs;
    priv_level_t mpp;
    logic [1:0]  vs;
    logic        spp;
    logic        mpie;
    logic        ube;
    logic        spie;
    logic        wpri1;
    logic        mie;
    logic        wpri2;
    logic        sie;
    logic        wpri3;
  } mstatus_t;

  typedef enum logic [1:0] {
    DIRECT   = 2'b00,
    VECTORED = 2'b01,
    RES_0    = 2'b10,
    RES_1    = 2'b11
  } mtvec_mode_t;

  typedef struct packed {
    logic [29:0] base;
    mtvec_mode_t mode;
  } mtvec_t;

  typedef struct packed {
    logic        irq;
    logic [30:0] code;
  } mcause_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    COMMIT   = 2'd2,
    REDIRECT = 2'd3
  } mtrap_state_t;

  typedef enum logic [1:0] {
    TK_INT  = 2'd0,
    TK_EXC  = 2'd1,
    TK_MRET = 2'd2
  } trap_kind_t;

endpackage

// File: rtl/mtrap_int_prio.sv
// Machine interrupt arbiter: picks the highest-priority enabled pending
// machine interrupt (MEI > MSI > MTI).
module mtrap_int_prio
  import machine_mode_types_1_12_pkg::*;
(
  input  logic      mei_i,
  input  logic      msi_i,
  input  logic      mti_i,
  input  logic      glob_en_i,
  output logic      valid_o,
  output int_code_t code_o
);

  always_comb begin
    valid_o = glob_en_i & (mei_i | msi_i | mti_i);
    code_o  = INT_MTI;
    if (mei_i) begin
      code_o = INT_MEI;
    end else if (msi_i) begin
      code_o = INT_MSI;
    end
  end

endmodule

// File: rtl/mtrap_sequencer.sv
// Machine-mode trap/MRET sequencer: arbitrates trap sources, drains the pipe,
// commits CSR state and privilege, then redirects fetch. MTVEC_VECTORED_EN enables vectored interrupts.
module mtrap_sequencer
  import machine_mode_types_1_12_pkg::*;
#(
  parameter priv_level_t RESET_PRIV  = M_MODE,
  parameter bit          U_MODE_SUPP = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        exc_valid_i,
  input  logic [30:0] exc_code_i,
  input  logic [31:0] exc_pc_i,
  input  logic [31:0] exc_tval_i,
  input  logic [31:0] int_pc_i,
  input  logic        mret_valid_i,
  input  mip_t        csr_mip_i,
  input  mie_t        csr_mie_i,
  input  mstatus_t    csr_mstatus_i,
  input  mtvec_t      csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic        pipe_quiesced_i,
  input  logic        redirect_ack_i,
  output logic        flush_req_o,
  output logic        csr_trap_we_o,
  output logic        csr_mret_we_o,
  output logic [31:0] mepc_wdata_o,
  output mcause_t     mcause_wdata_o,
  output logic [31:0] mtval_wdata_o,
  output mstatus_t    mstatus_wdata_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output priv_level_t priv_level_o,
  output logic        busy_o
);

  mtrap_state_t state_q, state_d;
  trap_kind_t   kind_q, kind_d;
  logic [30:0]  cause_q, cause_d;
  logic [29:0]  pc_q, pc_d;
  logic [31:0]  tval_q, tval_d;
  logic [31:0]  tgt_q, tgt_d;
  priv_level_t  priv_q, priv_d;

  logic [31:0]  pend;
  logic         glob_en;
  logic         int_valid;
  int_code_t    int_code;
  mstatus_t     ms_trap, ms_mret;
  priv_level_t  mret_priv;
  logic [31:0]  trap_base, trap_tgt;
  logic         unused_bits;

  assign pend    = csr_mip_i & csr_mie_i;
  assign glob_en = (priv_q != M_MODE) || csr_mstatus_i.mie;

  mtrap_int_prio u_int_prio (
    .mei_i    (pend[MEI_BIT]),
    .msi_i    (pend[MSI_BIT]),
    .mti_i    (pend[MTI_BIT]),
    .glob_en_i(glob_en),
    .valid_o  (int_valid),
    .code_o   (int_code)
  );

  always_comb begin
    ms_trap      = csr_mstatus_i;
    ms_trap.mpie = csr_mstatus_i.mie;
    ms_trap.mie  = 1'b0;
    ms_trap.mpp  = U_MODE_SUPP ? priv_q : M_MODE;

    // MPP values S and RESERVED map to U on MRET.
    if (!U_MODE_SUPP || csr_mstatus_i.mpp == M_MODE) begin
      mret_priv = M_MODE;
    end else begin
      mret_priv = U_MODE;
    end
    ms_mret      = csr_mstatus_i;
    ms_mret.mie  = csr_mstatus_i.mpie;
    ms_mret.mpie = 1'b1;
    ms_mret.mpp  = U_MODE_SUPP ? U_MODE : M_MODE;
    if (mret_priv != M_MODE) begin
      ms_mret.mprv = 1'b0;
    end
  end

  assign trap_base = {csr_mtvec_i.base, 2'b00};

`ifdef MTVEC_VECTORED_EN
  assign trap_tgt = (csr_mtvec_i.mode == VECTORED && kind_q == TK_INT) ?
                    trap_base + {cause_q[29:0], 2'b00} : trap_base;
  assign unused_bits = ^{exc_pc_i[1:0], int_pc_i[1:0], csr_mepc_i[1:0],
                         pend[31:12], pend[10:8], pend[6:4], pend[2:0]};
`else
  assign trap_tgt = trap_base;
  assign unused_bits = ^{exc_pc_i[1:0], int_pc_i[1:0], csr_mepc_i[1:0], csr_mtvec_i.mode,
                         pend[31:12], pend[10:8], pend[6:4], pend[2:0]};
`endif

  always_comb begin
    state_d          = state_q;
    kind_d           = kind_q;
    cause_d          = cause_q;
    pc_d             = pc_q;
    tval_d           = tval_q;
    tgt_d            = tgt_q;
    priv_d           = priv_q;
    flush_req_o      = 1'b0;
    csr_trap_we_o    = 1'b0;
    csr_mret_we_o    = 1'b0;
    mepc_wdata_o     = '0;
    mcause_wdata_o   = '0;
    mtval_wdata_o    = '0;
    mstatus_wdata_o  = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;

    case (state_q)
      IDLE: begin
        if (int_valid) begin
          kind_d  = TK_INT;
          cause_d = int_code;
          pc_d    = int_pc_i[31:2];
          tval_d  = '0;
          state_d = DRAIN;
        end else if (exc_valid_i) begin
          kind_d  = TK_EXC;
          cause_d = exc_code_i;
          pc_d    = exc_pc_i[31:2];
          tval_d  = exc_tval_i;
          state_d = DRAIN;
        end else if (mret_valid_i) begin
          kind_d  = TK_MRET;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        flush_req_o = 1'b1;
        if (pipe_quiesced_i) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        flush_req_o = 1'b1;
        state_d     = REDIRECT;
        if (kind_q == TK_MRET) begin
          csr_mret_we_o   = 1'b1;
          mstatus_wdata_o = ms_mret;
          priv_d          = mret_priv;
          tgt_d           = {csr_mepc_i[31:2], 2'b00};
        end else begin
          csr_trap_we_o       = 1'b1;
          mepc_wdata_o        = {pc_q, 2'b00};
          mcause_wdata_o.irq  = (kind_q == TK_INT);
          mcause_wdata_o.code = cause_q;
          mtval_wdata_o       = tval_q;
          mstatus_wdata_o     = ms_trap;
          priv_d              = M_MODE;
          tgt_d               = trap_tgt;
        end
      end
      REDIRECT: begin
        flush_req_o      = 1'b1;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = tgt_q;
        if (redirect_ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      kind_q  <= TK_INT;
      cause_q <= '0;
      pc_q    <= '0;
      tval_q  <= '0;
      tgt_q   <= '0;
      priv_q  <= RESET_PRIV;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
      tval_q  <= tval_d;
      tgt_q   <= tgt_d;
      priv_q  <= priv_d;
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign priv_level_o = priv_q;

endmodule

// File: tb/tb_mtrap_sequencer.sv
// Randomized bench for mtrap_sequencer against a bit-level model of the trap/MRET rules.
module tb_mtrap_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid;
  logic [30:0] exc_code;
  logic [31:0] exc_pc, exc_tval, int_pc;
  logic        mret_valid;
  logic [31:0] mip, mie, mstatus, mtvec, mepc;
  logic        pipe_quiesced, redirect_ack;
  logic        flush_req, csr_trap_we, csr_mret_we;
  logic [31:0] mepc_wdata, mcause_wdata, mtval_wdata, mstatus_wdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  priv_level;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] m_priv;

  always #5 clk = ~clk;

  mtrap_sequencer dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .exc_valid_i     (exc_valid),
    .exc_code_i      (exc_code),
    .exc_pc_i        (exc_pc),
    .exc_tval_i      (exc_tval),
    .int_pc_i        (int_pc),
    .mret_valid_i    (mret_valid),
    .csr_mip_i       (mip),
    .csr_mie_i       (mie),
    .csr_mstatus_i   (mstatus),
    .csr_mtvec_i     (mtvec),
    .csr_mepc_i      (mepc),
    .pipe_quiesced_i (pipe_quiesced),
    .redirect_ack_i  (redirect_ack),
    .flush_req_o     (flush_req),
    .csr_trap_we_o   (csr_trap_we),
    .csr_mret_we_o   (csr_mret_we),
    .mepc_wdata_o    (mepc_wdata),
    .mcause_wdata_o  (mcause_wdata),
    .mtval_wdata_o   (mtval_wdata),
    .mstatus_wdata_o (mstatus_wdata),
    .redirect_valid_o(redirect_valid),
    .redirect_pc_o   (redirect_pc),
    .priv_level_o    (priv_level),
    .busy_o          (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_req();
    exc_valid  = 1'b0;
    mret_valid = 1'b0;
    mip        = '0;
  endtask

  // One request cycle followed by the full sequence; d = DRAIN cycles with
  // pipe_quiesced low, r = REDIRECT cycles before ack.
  task automatic run_txn(input int d, input int r);
    logic [31:0] pend, e_mepc, e_mcause, e_mtval, e_ms, e_tgt;
    logic [1:0]  e_priv;
    bit          glob, got;
    int          kind, code, k;
    pend = mip & mie;
    glob = (m_priv != 2'b11) || mstatus[3];
    kind = 0;
    code = 0;
    if (glob && pend[11])     begin kind = 1; code = 11; end
    else if (glob && pend[3]) begin kind = 1; code = 3;  end
    else if (glob && pend[7]) begin kind = 1; code = 7;  end
    else if (exc_valid)       kind = 2;
    else if (mret_valid)      kind = 3;

    e_ms = mstatus;
    if (kind == 1 || kind == 2) begin
      e_mepc     = ((kind == 1) ? int_pc : exc_pc) & ~32'h3;
      e_mcause   = (kind == 1) ? (32'h8000_0000 | code) : {1'b0, exc_code};
      e_mtval    = (kind == 1) ? 32'h0 : exc_tval;
      e_ms[7]    = mstatus[3];
      e_ms[3]    = 1'b0;
      e_ms[12:11] = m_priv;
      e_priv     = 2'b11;
      e_tgt      = mtvec & ~32'h3;
`ifdef MTVEC_VECTORED_EN
      if (kind == 1 && mtvec[1:0] == 2'b01) e_tgt = e_tgt + 4 * code;
`endif
    end else begin
      e_mepc      = 0;
      e_mcause    = 0;
      e_mtval     = 0;
      e_priv      = (mstatus[12:11] == 2'b11) ? 2'b11 : 2'b00;
      e_ms[3]     = mstatus[7];
      e_ms[7]     = 1'b1;
      e_ms[12:11] = 2'b00;
      if (e_priv != 2'b11) e_ms[17] = 1'b0;
      e_tgt       = mepc & ~32'h3;
    end

    pipe_quiesced = 1'b0;
    redirect_ack  = 1'b0;
    @(negedge clk);
    if (kind == 0) begin
      check("idle_busy", busy, 0);
      check("idle_flush", flush_req, 0);
      return;
    end

    got = 0;
    for (k = 0; k < 40; k++) begin
      if (csr_trap_we || csr_mret_we) begin
        got = 1;
        break;
      end
      check("drain_flush", flush_req, 1);
      check("drain_busy", busy, 1);
      pipe_quiesced = (k >= d);
      exc_valid  = $urandom_range(0, 1);
      mret_valid = $urandom_range(0, 1);
      mip        = $urandom;
      @(negedge clk);
    end
    clear_req();
    check("commit_seen", got, 1);
    if (!got) return;
    check("commit_cycle", k, d + 1);
    check("commit_flush", flush_req, 1);
    check("trap_we", csr_trap_we, (kind != 3));
    check("mret_we", csr_mret_we, (kind == 3));
    check("mepc", mepc_wdata, e_mepc);
    check("mcause", mcause_wdata, e_mcause);
    check("mtval", mtval_wdata, e_mtval);
    check("mstatus", mstatus_wdata, e_ms);
    check("commit_redir", redirect_valid, 0);

    @(negedge clk);
    for (int j = 0; j <= r; j++) begin
      check("redir_valid", redirect_valid, 1);
      check("redir_pc", redirect_pc, e_tgt);
      check("redir_flush", flush_req, 1);
      check("redir_strobe", {csr_trap_we, csr_mret_we}, 0);
      check("redir_priv", priv_level, e_priv);
      if (j == r) redirect_ack = 1'b1;
      @(negedge clk);
    end
    redirect_ack = 1'b0;
    check("done_busy", busy, 0);
    check("done_redir", redirect_valid, 0);
    check("done_flush", flush_req, 0);
    check("done_priv", priv_level, e_priv);
    m_priv = e_priv;
  endtask

  task automatic zero_stim();
    clear_req();
    exc_code = '0; exc_pc = '0; exc_tval = '0; int_pc = '0;
    mie = '0; mstatus = '0; mtvec = '0; mepc = '0;
  endtask

  initial begin
    rst = 1'b1;
    zero_stim();
    pipe_quiesced = 1'b0;
    redirect_ack  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_priv", priv_level, 2'b11);
    check("rst_outs", {flush_req, csr_trap_we, csr_mret_we, redirect_valid}, 0);
    check("rst_wdata", mepc_wdata | mcause_wdata | mtval_wdata | mstatus_wdata | redirect_pc, 0);
    rst = 1'b0;
    m_priv = 2'b11;
    @(negedge clk);

    // MTI from M mode, DIRECT vector
    zero_stim();
    mstatus = 32'h0000_1808; mie = 32'h80; mip = 32'h80;
    int_pc = 32'h100; mtvec = 32'h8000_0000;
    run_txn(0, 0);

    // MEI beats MTI and a same-cycle illegal instruction
    zero_stim();
    mstatus = 32'h0000_0008; mie = 32'h880; mip = 32'h880;
    exc_valid = 1'b1; exc_code = 31'd2; exc_pc = 32'h300; int_pc = 32'h304;
    mtvec = 32'h8000_0000;
    run_txn(1, 1);

    // MRET back to U
    zero_stim();
    mret_valid = 1'b1; mstatus = 32'h0000_0080; mepc = 32'h204;
    run_txn(0, 0);

    // MSI taken from U despite mstatus.mie=0
    zero_stim();
    mie = 32'h8; mip = 32'h8; int_pc = 32'h2000; mtvec = 32'h4000_0000;
    run_txn(0, 1);

    // misaligned load with a slow drain
    zero_stim();
    exc_valid = 1'b1; exc_code = 31'd4; exc_tval = 32'h1003; exc_pc = 32'h400;
    mstatus = 32'h0000_1888; mtvec = 32'h8000_0000;
    run_txn(5, 2);

    for (int i = 0; i < 200; i++) begin
      exc_valid  = ($urandom_range(0, 3) == 0);
      exc_code   = 31'($urandom_range(0, 15));
      exc_pc     = $urandom;
      exc_tval   = $urandom;
      int_pc     = $urandom;
      mret_valid = ($urandom_range(0, 3) == 0);
      mip        = $urandom;
      mie        = ($urandom_range(0, 2) == 0) ? $urandom : 32'h0;
      mstatus    = $urandom;
      mtvec      = $urandom;
      mepc       = $urandom;
      run_txn($urandom_range(0, 4), $urandom_range(0, 3));
    end

    // reset while draining: no CSR write, privilege back to reset value
    zero_stim();
    mret_valid = 1'b1; mstatus = 32'h0000_0080; mepc = 32'h600;
    run_txn(0, 0);
    zero_stim();
    exc_valid = 1'b1; exc_code = 31'd2; exc_pc = 32'h700;
    pipe_quiesced = 1'b0;
    @(negedge clk);
    clear_req();
    check("pre_rst_busy", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_outs", {flush_req, csr_trap_we, csr_mret_we, redirect_valid}, 0);
    check("midrst_priv", priv_level, 2'b11);
    rst = 1'b0;
    pipe_quiesced = 1'b1;
    m_priv = 2'b11;
    repeat (4) begin
      @(negedge clk);
      check("postrst_strobe", {csr_trap_we, csr_mret_we, busy}, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
